// File: rtl/game_phase_sequencer.sv
// ----------------------------------------------------------------------------
// game_phase_sequencer
//
// Top-level game sequencer for the VGA build. Synchronises and debounces the
// three push buttons, detects frame starts from the display vSync, and steps
// the game phase FSM IDLE -> COUNTDOWN -> PLAY <-> PAUSE, PLAY -> OVER -> IDLE.
// While playing it issues one move tick every FRAMES_PER_MOVE frames, carrying
// the most recent steer request made since the previous tick.
//
// Ports
//   ClkPort    in   1  system clock (100 MHz)
//   Reset      in   1  asynchronous, active-high reset
//   BtnU       in   1  raw start/pause/acknowledge button (asynchronous)
//   BtnL       in   1  raw steer-left button (asynchronous)
//   BtnR       in   1  raw steer-right button (asynchronous)
//   vSync      in   1  display vSync, active-low pulse (asynchronous)
//   game_over  in   1  level from fpsr_controller, synchronous to ClkPort
//   state      out  3  0 IDLE, 1 COUNTDOWN, 2 PLAY, 3 PAUSE, 4 OVER
//   countdown  out  4  remaining countdown value, 0 outside COUNTDOWN
//   move_tick  out  1  one-cycle move pulse, only ever high in PLAY
//   move_dir   out  2  00 none, 01 left, 10 right; valid with move_tick
//   sw_en      out  1  switch_controller (overlay) enable
//   fc_en      out  1  fpsr_controller enable
//   bc_en      out  1  board_controller enable
// ----------------------------------------------------------------------------
module game_phase_sequencer #(
    parameter int unsigned DEBOUNCE_CYCLES   = 1_000_000,
    parameter int unsigned COUNT_TICK_CYCLES = 100_000_000,
    parameter int unsigned COUNTDOWN_TICKS   = 3,
    parameter int unsigned FRAMES_PER_MOVE   = 2
) (
    input  logic       ClkPort,
    input  logic       Reset,
    input  logic       BtnU,
    input  logic       BtnL,
    input  logic       BtnR,
    input  logic       vSync,
    input  logic       game_over,
    output logic [2:0] state,
    output logic [3:0] countdown,
    output logic       move_tick,
    output logic [1:0] move_dir,
    output logic       sw_en,
    output logic       fc_en,
    output logic       bc_en
);

    localparam int unsigned DbW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int unsigned StW = $clog2(COUNT_TICK_CYCLES) + 1;
    localparam int unsigned FrW = $clog2(FRAMES_PER_MOVE) + 1;

    localparam logic [DbW-1:0] DbMax   = DbW'(DEBOUNCE_CYCLES - 1);
    localparam logic [StW-1:0] StepMax = StW'(COUNT_TICK_CYCLES - 1);
    localparam logic [FrW-1:0] FrMax   = FrW'(FRAMES_PER_MOVE - 1);
    localparam logic [3:0]     CdStart = 4'(COUNTDOWN_TICKS);

    // Button vector index
    localparam int unsigned IdxU = 0;
    localparam int unsigned IdxL = 1;
    localparam int unsigned IdxR = 2;

    typedef enum logic [2:0] {
        StIdle      = 3'd0,
        StCountdown = 3'd1,
        StPlay      = 3'd2,
        StPause     = 3'd3,
        StOver      = 3'd4
    } state_e;

    // ------------------------------------------------------------------
    // Input synchronisers and debouncers
    // ------------------------------------------------------------------
    logic [2:0]     btn_raw;
    logic [2:0]     btn_s1_q, btn_s2_q;
    logic [2:0]     deb_q, deb_d, deb_prev_q;
    logic [DbW-1:0] db_cnt_q [3];
    logic [DbW-1:0] db_cnt_d [3];
    logic [2:0]     press;
    logic           press_u, press_l, press_r;

    logic vs_s1_q, vs_s2_q, vs_prev_q;
    logic frame_start;

    assign btn_raw = {BtnR, BtnL, BtnU};

    always_ff @(posedge ClkPort or posedge Reset) begin
        if (Reset) begin
            btn_s1_q   <= '0;
            btn_s2_q   <= '0;
            deb_q      <= '0;
            deb_prev_q <= '0;
            for (int i = 0; i < 3; i++) begin
                db_cnt_q[i] <= '0;
            end
            vs_s1_q   <= 1'b0;
            vs_s2_q   <= 1'b0;
            vs_prev_q <= 1'b0;
        end else begin
            btn_s1_q   <= btn_raw;
            btn_s2_q   <= btn_s1_q;
            deb_q      <= deb_d;
            deb_prev_q <= deb_q;
            for (int i = 0; i < 3; i++) begin
                db_cnt_q[i] <= db_cnt_d[i];
            end
            vs_s1_q   <= vSync;
            vs_s2_q   <= vs_s1_q;
            vs_prev_q <= vs_s2_q;
        end
    end

    // The counter only runs while the synced level disagrees with the
    // debounced level; any agreement (a bounce back) restarts it.
    always_comb begin
        deb_d    = deb_q;
        db_cnt_d = '{default: '0};
        for (int i = 0; i < 3; i++) begin
            if (btn_s2_q[i] != deb_q[i]) begin
                if (db_cnt_q[i] == DbMax) begin
                    deb_d[i] = btn_s2_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign press   = deb_q & ~deb_prev_q;
    assign press_u = press[IdxU];
    assign press_l = press[IdxL];
    assign press_r = press[IdxR];

    // vSync is active-low: a frame begins on its falling edge.
    assign frame_start = vs_prev_q & ~vs_s2_q;

    // ------------------------------------------------------------------
    // Phase FSM and datapath
    // ------------------------------------------------------------------
    state_e         state_q, state_d;
    logic [3:0]     countdown_q, countdown_d;
    logic [StW-1:0] step_q, step_d;
    logic [FrW-1:0] frame_q, frame_d;
    logic [1:0]     pend_q, pend_d;
    logic           tick_q, tick_d;
    logic [1:0]     dir_q, dir_d;
    logic           sw_en_q, sw_en_d;
    logic           fc_en_q, fc_en_d;
    logic           bc_en_q, bc_en_d;

    // State register
    always_ff @(posedge ClkPort or posedge Reset) begin
        if (Reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and datapath logic
    always_comb begin
        state_d     = state_q;
        countdown_d = countdown_q;
        step_d      = step_q;
        frame_d     = frame_q;
        pend_d      = pend_q;
        tick_d      = 1'b0;
        dir_d       = 2'b00;

        case (state_q)
            StIdle: begin
                if (press_u) begin
                    state_d     = StCountdown;
                    countdown_d = CdStart;
                    step_d      = '0;
                end
            end

            StCountdown: begin
                if (step_q == StepMax) begin
                    step_d = '0;
                    if (countdown_q == 4'd1) begin
                        state_d     = StPlay;
                        countdown_d = 4'd0;
                        frame_d     = '0;
                        pend_d      = 2'b00;
                    end else begin
                        countdown_d = countdown_q - 4'd1;
                    end
                end else begin
                    step_d = step_q + 1'b1;
                end
            end

            StPlay: begin
                // Frame/tick logic only runs when staying in PLAY, so no tick
                // can appear in the cycle the FSM leaves PLAY.
                if (game_over) begin
                    state_d = StOver;
                end else if (press_u) begin
                    state_d = StPause;
                end else if (frame_start) begin
                    if (frame_q == FrMax) begin
                        frame_d = '0;
                        tick_d  = 1'b1;
                        dir_d   = pend_q;
                        pend_d  = 2'b00;
                    end else begin
                        frame_d = frame_q + 1'b1;
                    end
                end
                // A press overrides the post-consume clear, so it lands in
                // the pending slot for the following tick.
                if (press_l && !press_r) begin
                    pend_d = 2'b01;
                end else if (press_r && !press_l) begin
                    pend_d = 2'b10;
                end
            end

            StPause: begin
                if (press_u) begin
                    state_d = StPlay;
                end
            end

            StOver: begin
                if (press_u) begin
                    state_d = StIdle;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Output logic: enables follow the next state so they change together
    // with the registered state.
    always_comb begin
        bc_en_d = 1'b1;
        fc_en_d = (state_d == StPlay) || (state_d == StPause) || (state_d == StOver);
        sw_en_d = (state_d != StPlay);
    end

    always_ff @(posedge ClkPort or posedge Reset) begin
        if (Reset) begin
            countdown_q <= 4'd0;
            step_q      <= '0;
            frame_q     <= '0;
            pend_q      <= 2'b00;
            tick_q      <= 1'b0;
            dir_q       <= 2'b00;
            sw_en_q     <= 1'b1;
            fc_en_q     <= 1'b0;
            bc_en_q     <= 1'b1;
        end else begin
            countdown_q <= countdown_d;
            step_q      <= step_d;
            frame_q     <= frame_d;
            pend_q      <= pend_d;
            tick_q      <= tick_d;
            dir_q       <= dir_d;
            sw_en_q     <= sw_en_d;
            fc_en_q     <= fc_en_d;
            bc_en_q     <= bc_en_d;
        end
    end

    assign state     = state_q;
    assign countdown = countdown_q;
    assign move_tick = tick_q;
    assign move_dir  = dir_q;
    assign sw_en     = sw_en_q;
    assign fc_en     = fc_en_q;
    assign bc_en     = bc_en_q;

endmodule
